// File: rtl/answer_judge_if.sv
// Round-judge bus: round control, problem word, both answer channels and the verdict/status outputs.
interface answer_judge_if;
    logic        ROUND_START;
    logic [35:0] DB_IN;
    logic        MY_VALID;
    logic [15:0] MY_ANS;
    logic        EN_VALID;
    logic [15:0] EN_ANS;
    logic [2:0]  RESULT;
    logic        BUSY;
    logic        MY_LOCK;
    logic        EN_LOCK;

    // Stimulus side: drives the round control and answers, observes the verdict.
    modport master (
        output ROUND_START, DB_IN, MY_VALID, MY_ANS, EN_VALID, EN_ANS,
        input  RESULT, BUSY, MY_LOCK, EN_LOCK
    );

    // Judge side.
    modport slave (
        input  ROUND_START, DB_IN, MY_VALID, MY_ANS, EN_VALID, EN_ANS,
        output RESULT, BUSY, MY_LOCK, EN_LOCK
    );
endinterface

// File: rtl/answer_judge.sv
// Factorization-duel round judge: latches P/Q at round start, judges both players'
// answers, and emits a single-cycle verdict code (001 own, 010 opponent, 011 draw).
module answer_judge #(
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic           CLK,
    input  logic           RST,
    answer_judge_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [2:0]       RES_NONE = 3'b000;
    localparam logic [2:0]       RES_MY   = 3'b001;
    localparam logic [2:0]       RES_EN   = 3'b010;
    localparam logic [2:0]       RES_DRAW = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [7:0]       r_p;
    logic [7:0]       r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_my_lock;
    logic             r_en_lock;
    logic [2:0]       r_result;
    logic             r_busy;

    logic             w_load;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_my_lock_nxt;
    logic             w_en_lock_nxt;
    logic [2:0]       w_result_nxt;
    logic             w_busy_nxt;

    logic             w_my_cnt;
    logic             w_en_cnt;
    logic             w_my_win;
    logic             w_en_win;
    logic             w_my_wrong;
    logic             w_en_wrong;
    logic [2:0]       w_code;

    // Exact factor-pair match, either order.
    function automatic logic f_match(input logic [15:0] ans, input logic [7:0] p, input logic [7:0] q);
        return (ans == {p, q}) || (ans == {q, p});
    endfunction

    // Per-cycle decision from the strobes that count this cycle.
    always_comb begin
        w_my_cnt   = bus.MY_VALID & ~r_my_lock;
        w_en_cnt   = bus.EN_VALID & ~r_en_lock;
        w_my_win   = w_my_cnt &  f_match(bus.MY_ANS, r_p, r_q);
        w_en_win   = w_en_cnt &  f_match(bus.EN_ANS, r_p, r_q);
        w_my_wrong = w_my_cnt & ~f_match(bus.MY_ANS, r_p, r_q);
        w_en_wrong = w_en_cnt & ~f_match(bus.EN_ANS, r_p, r_q);
        w_code     = RES_NONE;
        if (w_my_win && w_en_win) begin
            w_code = RES_DRAW;
        end else if (w_my_win) begin
            w_code = RES_MY;
        end else if (w_en_win) begin
            w_code = RES_EN;
        end else if ((r_my_lock | w_my_wrong) && (r_en_lock | w_en_wrong)) begin
            w_code = RES_DRAW;
        end else if (r_cnt == CNT_LAST) begin
            w_code = RES_DRAW;
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (bus.ROUND_START) w_state_nxt = S_ARMED;
            S_ARMED:  if (w_code != RES_NONE) w_state_nxt = S_REPORT;
            S_REPORT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output/datapath next values; REPORT holds everything and lets RESULT fall to zero.
    always_comb begin
        w_load        = 1'b0;
        w_cnt_nxt     = r_cnt;
        w_my_lock_nxt = r_my_lock;
        w_en_lock_nxt = r_en_lock;
        w_result_nxt  = RES_NONE;
        w_busy_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.ROUND_START) begin
                    w_load        = 1'b1;
                    w_cnt_nxt     = '0;
                    w_my_lock_nxt = 1'b0;
                    w_en_lock_nxt = 1'b0;
                    w_busy_nxt    = 1'b1;
                end
            end
            S_ARMED: begin
                w_cnt_nxt     = r_cnt + CNT_W'(1);
                w_my_lock_nxt = r_my_lock | w_my_wrong;
                w_en_lock_nxt = r_en_lock | w_en_wrong;
                w_result_nxt  = w_code;
                w_busy_nxt    = (w_code == RES_NONE);
            end
            default: begin
            end
        endcase
    end

    // Registered outputs, counter and locks.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt     <= '0;
            r_my_lock <= 1'b0;
            r_en_lock <= 1'b0;
            r_result  <= RES_NONE;
            r_busy    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_my_lock <= w_my_lock_nxt;
            r_en_lock <= w_en_lock_nxt;
            r_result  <= w_result_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // Problem factors, captured only when a round opens.
    always_ff @(posedge CLK) begin
        if (w_load) begin
            r_p <= bus.DB_IN[15:8];
            r_q <= bus.DB_IN[7:0];
        end
    end

    assign bus.RESULT  = r_result;
    assign bus.BUSY    = r_busy;
    assign bus.MY_LOCK = r_my_lock;
    assign bus.EN_LOCK = r_en_lock;

endmodule

// File: tb/tb_answer_judge.sv
// Directed bench for answer_judge: stimulus pushes expected verdicts/status into queues,
// a negedge monitor pops and compares them.
module tb_answer_judge;

    typedef struct packed {
        logic [31:0] cyc;
        logic [2:0]  code;
    } vexp_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic        busy;
        logic        ml;
        logic        el;
    } sexp_t;

    localparam logic [35:0] DB1 = 36'h4_00DD_0D11;  // P=0x0D Q=0x11
    localparam logic [35:0] DB2 = 36'h8_000F_0305;  // P=0x03 Q=0x05

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    vexp_t       vq[$];
    sexp_t       sq[$];

    answer_judge_if bus();

    answer_judge #(.TIMEOUT_CYC(8), .CNT_W(4)) u_dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: verdict scoreboard plus scheduled status checks.
    always @(negedge clk) begin : mon
        vexp_t v;
        sexp_t s;
        if (bus.RESULT !== 3'b000) begin
            n_vec++;
            if (vq.size() == 0) begin
                n_err++;
                $display("FAIL verdict_unexpected: cycle %0d RESULT=%b, required 000", cyc, bus.RESULT);
            end else begin
                v = vq.pop_front();
                if (v.code !== bus.RESULT || v.cyc != 32'(cyc)) begin
                    n_err++;
                    $display("FAIL verdict: got RESULT=%b at cycle %0d, required %b at cycle %0d",
                             bus.RESULT, cyc, v.code, v.cyc);
                end
            end
        end else if (vq.size() > 0 && vq[0].cyc <= 32'(cyc)) begin
            v = vq.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL verdict_missing: cycle %0d RESULT=000, required %b at cycle %0d", cyc, v.code, v.cyc);
        end
        while (sq.size() > 0 && sq[0].cyc <= 32'(cyc)) begin
            s = sq.pop_front();
            n_vec++;
            if ({bus.BUSY, bus.MY_LOCK, bus.EN_LOCK} !== {s.busy, s.ml, s.el} || s.cyc != 32'(cyc)) begin
                n_err++;
                $display("FAIL status: cycle %0d BUSY/MY_LOCK/EN_LOCK=%b%b%b, required %b%b%b at cycle %0d",
                         cyc, bus.BUSY, bus.MY_LOCK, bus.EN_LOCK, s.busy, s.ml, s.el, s.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) tick();
    endtask

    task automatic push_v(input int unsigned c, input logic [2:0] code);
        vexp_t v;
        v.cyc  = 32'(c);
        v.code = code;
        vq.push_back(v);
    endtask

    task automatic st(input int unsigned c, input logic b, input logic ml, input logic el);
        sexp_t s;
        s.cyc  = 32'(c);
        s.busy = b;
        s.ml   = ml;
        s.el   = el;
        sq.push_back(s);
    endtask

    task automatic start_at(input int unsigned c, input logic [35:0] db);
        wait_until(c);
        bus.DB_IN       = db;
        bus.ROUND_START = 1'b1;
        tick();
        bus.ROUND_START = 1'b0;
    endtask

    task automatic my_at(input int unsigned c, input logic [15:0] a);
        wait_until(c);
        bus.MY_ANS   = a;
        bus.MY_VALID = 1'b1;
        tick();
        bus.MY_VALID = 1'b0;
    endtask

    task automatic en_at(input int unsigned c, input logic [15:0] a);
        wait_until(c);
        bus.EN_ANS   = a;
        bus.EN_VALID = 1'b1;
        tick();
        bus.EN_VALID = 1'b0;
    endtask

    task automatic both_at(input int unsigned c, input logic [15:0] a, input logic [15:0] b);
        wait_until(c);
        bus.MY_ANS   = a;
        bus.EN_ANS   = b;
        bus.MY_VALID = 1'b1;
        bus.EN_VALID = 1'b1;
        tick();
        bus.MY_VALID = 1'b0;
        bus.EN_VALID = 1'b0;
    endtask

    // Directed stimulus; cycle numbers are absolute.
    initial begin
        bus.ROUND_START = 1'b0;
        bus.DB_IN       = '0;
        bus.MY_VALID    = 1'b0;
        bus.MY_ANS      = '0;
        bus.EN_VALID    = 1'b0;
        bus.EN_ANS      = '0;

        // Reset values
        wait_until(3);
        rst = 1'b0;
        st(3, 0, 0, 0);

        // Own correct, swapped order
        st(6, 1, 0, 0); push_v(9, 3'b001); st(9, 0, 0, 0); st(10, 0, 0, 0);
        start_at(5, DB1);
        my_at(8, 16'h110D);

        // Opponent first, own later ignored
        push_v(15, 3'b010); st(15, 0, 0, 0); st(16, 0, 0, 0);
        start_at(12, DB1);
        en_at(14, 16'h0D11);
        my_at(15, 16'h0D11);

        // Simultaneous correct
        push_v(20, 3'b011); st(20, 0, 0, 0);
        start_at(18, DB1);
        both_at(19, 16'h0D11, 16'h110D);

        // Own wrong then locked, opponent wrong -> draw
        st(23, 1, 0, 0); st(25, 1, 1, 0); st(26, 1, 1, 0);
        push_v(27, 3'b011); st(27, 0, 1, 1); st(28, 0, 1, 1);
        start_at(22, DB1);
        my_at(24, 16'h0102);
        my_at(25, 16'h0D11);
        en_at(26, 16'h0102);

        // Timeout with no strobes
        st(31, 1, 0, 0); st(38, 1, 0, 0); push_v(39, 3'b011); st(39, 0, 0, 0);
        start_at(30, DB1);

        // Correct answer on the timeout cycle wins
        push_v(50, 3'b001); st(50, 0, 0, 0);
        start_at(41, DB1);
        my_at(49, 16'h0D11);

        // Reset mid-round, then a normal round
        st(53, 1, 0, 0); st(55, 1, 1, 0); st(56, 0, 0, 0); st(58, 0, 0, 0);
        st(61, 1, 0, 0); push_v(63, 3'b001); st(63, 0, 0, 0);
        start_at(52, DB1);
        my_at(54, 16'h0102);
        wait_until(55);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        my_at(57, 16'h0D11);
        start_at(60, DB1);
        my_at(62, 16'h110D);

        // Ignored start while ARMED and during REPORT, then back-to-back start
        st(66, 1, 0, 0); st(69, 1, 0, 1); st(73, 1, 0, 1); push_v(74, 3'b011);
        st(75, 0, 0, 1); st(76, 1, 0, 0); push_v(78, 3'b001); st(78, 0, 0, 0);
        start_at(65, DB1);
        start_at(67, DB2);
        en_at(68, 16'h0305);
        start_at(74, DB2);
        start_at(75, DB2);
        my_at(77, 16'h0503);

        wait_until(81);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/answer_judge.md
# answer_judge

Round judge for the factorization duel. On a round start it latches the current problem from the problem database, then watches both players' answer submissions and decides who factored the number first. It emits a one-cycle verdict code on `RESULT`, which feeds the HP manager's `HP_IN` directly.

## Interface
- `TIMEOUT_CYC`, default 1000: cycles a round stays open before it is forced to a draw; must be ≥2.
- `CNT_W`, default 16: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

- `CLK`, in, 1: single clock; all state changes on its rising edge.
- `RST`, in, 1: reset, synchronous and active-high.
- `ROUND_START`, in, 1: pulse that opens a round; honoured only in IDLE.
- `DB_IN`, in, 36: problem word, with this layout:
  - `[35:34]` level
  - `[33:16]` composite
  - `[15:8]` factor P
  - `[7:0]` factor Q
- `MY_VALID`, in, 1: own-player answer strobe, one cycle.
- `MY_ANS`, in, 16: own answer; `[15:8]` and `[7:0]` are the two claimed factors.
- `EN_VALID`, in, 1: opponent answer strobe.
- `EN_ANS`, in, 16: opponent answer, same layout as `MY_ANS`.
- `RESULT`, out, 3: verdict pulse.
  - 3'b000: none
  - 3'b001: own player first correct
  - 3'b010: opponent first correct
  - 3'b011: draw
- `BUSY`, out, 1: high while a round is open (ARMED).
- `MY_LOCK`, out, 1: own player has answered wrong this round.
- `EN_LOCK`, out, 1: opponent has answered wrong this round.

## Operation
- States: IDLE, ARMED, REPORT.
- IDLE:
  - `ROUND_START`=1 latches `DB_IN[15:0]` into P/Q.
  - Clears both locks and the counter.
  - Next state is ARMED.
  - Answer strobes are ignored.
- ARMED:
  - The counter increments every cycle.
  - `ROUND_START` is ignored.
- Correctness test: an answer is correct if {hi,lo} == {P,Q} or {hi,lo} == {Q,P}. The comparison is exact over 8 bits, with no arithmetic check against the composite.
- Per player, a strobe counts only when that player's lock=0.
  - A wrong answer sets that player's lock, which stays set until the next round.
  - A locked player's later strobes are ignored.
- Decision, evaluated each ARMED cycle on the counted strobes:
  - Only own player correct → 001.
  - Only opponent correct → 010.
  - Both correct in the same cycle → 011.
  - One correct and the other wrong in the same cycle → the correct player wins. The wrong player's lock is still set.
  - Both locks set (including both wrong in the same cycle) → 011.
  - Counter == TIMEOUT_CYC−1 with no other decision → 011. A correct answer in that same cycle takes precedence over the timeout.
- On a decision, the code is registered into `RESULT` and the FSM moves to REPORT.
- REPORT:
  - Lasts exactly one cycle with `RESULT` = code.
  - Then IDLE, with `RESULT` back to 000.
  - A `ROUND_START` during REPORT is dropped.
- `RESULT` is non-zero only in REPORT and is never held across cycles, so the HP manager counts each round exactly once.
- Reset:
  - `RST`=1 at any time, including mid-round, forces IDLE.
  - All outputs return to 0.
  - Locks and counter clear.
  - Latched P/Q need not be cleared.
  - No verdict is emitted for an aborted round.

## Timing
- Reset values: `RESULT`=000, `BUSY`=0, `MY_LOCK`=0, `EN_LOCK`=0.
- `ROUND_START` in cycle n → `BUSY`=1 from cycle n+1. Strobes are counted from cycle n+1.
- Deciding strobe in cycle m → `RESULT` valid in cycle m+1 only. `BUSY` falls in cycle m+1.
- Wrong strobe in cycle m → the lock output is high from cycle m+1.
- Timeout: `ROUND_START` in cycle n with no answers → `RESULT`=011 in cycle n+TIMEOUT_CYC+1.
- Back-to-back rounds: the earliest accepted next `ROUND_START` is in the cycle after REPORT.
- `DB_IN` needs to be stable only in the `ROUND_START` cycle.

## Test plan
- Own correct, swapped order:
  - Stimulus: P=0x0D, Q=0x11; start; 3 cycles later `MY_ANS`=0x110D strobe.
  - Response: `RESULT`=001 for exactly 1 cycle, the next cycle; then 000; `BUSY` low.
- Opponent first, own later:
  - Stimulus: `EN_ANS`=0x0D11 at cycle 2; `MY_ANS`=0x0D11 at cycle 3.
  - Response: single 010 pulse; the own strobe is ignored.
- Simultaneous correct, then lockout:
  - Stimulus: both correct strobes in the same cycle.
  - Response: 011.
  - Second round: own wrong (0x0102), then own correct.
  - Response: `MY_LOCK`=1 and no verdict.
  - Then opponent wrong.
  - Response: 011 the cycle after.
- Timeout with TIMEOUT_CYC=8:
  - Stimulus: start, no strobes.
  - Response: `RESULT`=011 exactly 9 cycles after start.
  - Stimulus: own correct at counter=7.
  - Response: 001, not 011.
- Reset mid-round:
  - Stimulus: `RST` at cycle 3 of a round, with a correct strobe at cycle 5.
  - Response: all outputs 0 and no verdict.
  - Stimulus: a subsequent start plus a correct answer.
  - Response: normal 001.
- Ignored starts:
  - Stimulus: `ROUND_START` while ARMED with a new `DB_IN` (P/Q=0x0305).
  - Response: old P/Q still judged; the counter is not restarted.
  - Stimulus: `ROUND_START` during REPORT.
  - Response: `BUSY` stays 0.
